// File: rtl/sb_arb.sv
// sb_arb: two-master to one-slave round-robin arbiter with a transfer timeout.
//
// A master requests with re|we (both set means write). The granted master's
// command is latched on the grant edge and presented to the slave for the
// whole transfer. The slave answers with a one-cycle s_ready. If s_ready does
// not arrive within TIMEOUT cycles, the transfer is aborted and reported as an
// error. Completion is a one-cycle done pulse, with err qualifying it.
//
// Ports
//   clk, rst                     clock, async active-low reset
//   mX_re, mX_we                 master X read / write request
//   mX_addr, mX_wdata            master X address / write data
//   mX_byte_mask, mX_un_sign     master X byte lanes / unsigned-load flag
//   mX_done_o, mX_err_o          master X completion pulse / timeout flag
//   mX_rdata_o                   master X read data (held between transfers)
//   s_re_o, s_we_o               slave strobes, high for the whole transfer
//   s_addr_o .. s_un_sign_o      latched command of the granted master
//   s_rdata, s_ready             slave read data / one-cycle completion
//
// state | meaning
// IDLE  | waiting for a request, arbitration happens here only
// BUSY  | strobe driven, waiting for s_ready or timeout
// RESP  | one-cycle done pulse to the owner, strobes low
module sb_arb #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_re,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byte_mask,
    input  logic        m0_un_sign,
    output logic        m0_done_o,
    output logic        m0_err_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_re,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byte_mask,
    input  logic        m1_un_sign,
    output logic        m1_done_o,
    output logic        m1_err_o,
    output logic [31:0] m1_rdata_o,
    output logic        s_re_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_byte_mask_o,
    output logic        s_un_sign_o,
    input  logic [31:0] s_rdata,
    input  logic        s_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic       r_owner;
    logic       r_last;
    logic [7:0] r_cnt;

    logic w_req0;
    logic w_req1;
    logic w_grant;
    logic w_sel_re;
    logic w_sel_we;

    assign w_req0   = m0_re | m0_we;
    assign w_req1   = m1_re | m1_we;
    // On a tie the master that was not served last wins; otherwise the sole requester.
    assign w_grant  = (w_req0 & w_req1) ? ~r_last : w_req1;
    assign w_sel_re = w_grant ? m1_re : m0_re;
    assign w_sel_we = w_grant ? m1_we : m0_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_owner       <= 1'b0;
            r_last        <= 1'b1;
            r_cnt         <= '0;
            s_re_o        <= 1'b0;
            s_we_o        <= 1'b0;
            s_addr_o      <= '0;
            s_wdata_o     <= '0;
            s_byte_mask_o <= '0;
            s_un_sign_o   <= 1'b0;
            m0_done_o     <= 1'b0;
            m0_err_o      <= 1'b0;
            m0_rdata_o    <= '0;
            m1_done_o     <= 1'b0;
            m1_err_o      <= 1'b0;
            m1_rdata_o    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_owner       <= w_grant;
                        s_addr_o      <= w_grant ? m1_addr      : m0_addr;
                        s_wdata_o     <= w_grant ? m1_wdata     : m0_wdata;
                        s_byte_mask_o <= w_grant ? m1_byte_mask : m0_byte_mask;
                        s_un_sign_o   <= w_grant ? m1_un_sign   : m0_un_sign;
                        s_we_o        <= w_sel_we;
                        s_re_o        <= w_sel_re & ~w_sel_we;
                        r_cnt         <= '0;
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    // s_ready is tested first so it wins over a coincident timeout.
                    if (s_ready || (r_cnt == LP_CNT_LAST)) begin
                        r_state <= RESP;
                        s_re_o  <= 1'b0;
                        s_we_o  <= 1'b0;
                        if (r_owner) begin
                            m1_done_o <= 1'b1;
                            m1_err_o  <= ~s_ready;
                            if (!s_ready)
                                m1_rdata_o <= '0;
                            else if (s_re_o)
                                m1_rdata_o <= s_rdata;
                        end else begin
                            m0_done_o <= 1'b1;
                            m0_err_o  <= ~s_ready;
                            if (!s_ready)
                                m0_rdata_o <= '0;
                            else if (s_re_o)
                                m0_rdata_o <= s_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    m0_done_o <= 1'b0;
                    m0_err_o  <= 1'b0;
                    m1_done_o <= 1'b0;
                    m1_err_o  <= 1'b0;
                    r_last    <= r_owner;
                    r_cnt     <= '0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_arb.sv
module tb_sb_arb;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_re    [2];
    logic        m_we    [2];
    logic        m_uns   [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_mask  [2];
    logic        s_ready;
    logic [31:0] s_rdata;

    wire        m0_done_o, m0_err_o, m1_done_o, m1_err_o;
    wire [31:0] m0_rdata_o, m1_rdata_o;
    wire        s_re_o, s_we_o, s_un_sign_o;
    wire [31:0] s_addr_o, s_wdata_o;
    wire [3:0]  s_byte_mask_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_rd [2];

    int          lat, nstb;
    bit          cmd_ok, dir_ok, early, dn, er, od;
    logic [31:0] ro, rt;

    always #5 clk = ~clk;

    sb_arb #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_re(m_re[0]), .m0_we(m_we[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]),
        .m0_byte_mask(m_mask[0]), .m0_un_sign(m_uns[0]),
        .m0_done_o(m0_done_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
        .m1_re(m_re[1]), .m1_we(m_we[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]),
        .m1_byte_mask(m_mask[1]), .m1_un_sign(m_uns[1]),
        .m1_done_o(m1_done_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
        .s_re_o(s_re_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_byte_mask_o(s_byte_mask_o), .s_un_sign_o(s_un_sign_o),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    function automatic logic get_done(int m);
        return (m == 1) ? m1_done_o : m0_done_o;
    endfunction

    function automatic logic get_err(int m);
        return (m == 1) ? m1_err_o : m0_err_o;
    endfunction

    function automatic logic [31:0] get_rd(int m);
        return (m == 1) ? m1_rdata_o : m0_rdata_o;
    endfunction

    function automatic logic [138:0] all_outs();
        return {s_re_o, s_we_o, s_addr_o, s_wdata_o, s_byte_mask_o, s_un_sign_o,
                m0_done_o, m0_err_o, m0_rdata_o, m1_done_o, m1_err_o, m1_rdata_o};
    endfunction

    // Drives one transfer from master m, answering s_ready in strobe cycle rdy_k
    // (-1: never). Records what was observed; callers do the comparing.
    task automatic run_xfer(input int m, input bit re, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] mask, input bit uns,
                            input int rdy_k, input logic [31:0] srd);
        bit exp_we, exp_re;
        exp_we = we;
        exp_re = re & ~we;
        lat = 0; nstb = 0; cmd_ok = 1; dir_ok = 1; early = 0;
        m_re[m] = re; m_we[m] = we; m_addr[m] = addr; m_wdata[m] = wdata;
        m_mask[m] = mask; m_uns[m] = uns;
        while (!(s_re_o | s_we_o) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        // Master changes its command after grant; slave side must not follow.
        m_addr[m] = $urandom; m_wdata[m] = $urandom; m_mask[m] = 4'($urandom); m_uns[m] = ~uns;
        while ((s_re_o | s_we_o) && nstb < 300) begin
            nstb++;
            if (s_addr_o !== addr || s_wdata_o !== wdata || s_byte_mask_o !== mask ||
                s_un_sign_o !== uns) cmd_ok = 0;
            if (s_we_o !== exp_we || s_re_o !== exp_re) dir_ok = 0;
            if (m0_done_o | m1_done_o) early = 1;
            s_ready = (nstb - 1 == rdy_k);
            s_rdata = (nstb - 1 == rdy_k) ? srd : $urandom;
            @(negedge clk);
        end
        s_ready = 0;
        dn = get_done(m); er = get_err(m); od = get_done(1 - m);
        ro = get_rd(m); rt = get_rd(1 - m);
        m_re[m] = 0; m_we[m] = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
        rst = 1;
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL idle_after_reset: got %h required 0", all_outs());
        end
        exp_rd[0] = 0; exp_rd[1] = 0;
    endtask

    task automatic test_read();
        run_xfer(0, 1, 0, 32'h100, 32'h0, 4'hF, 0, 1, 32'hDEADBEEF);
        checks++; if (lat !== 1) begin errors++; $display("FAIL read_latency: got %0d required 1", lat); end
        checks++; if (nstb !== 2) begin errors++; $display("FAIL read_strobe_len: got %0d required 2", nstb); end
        checks++; if (!cmd_ok || !dir_ok) begin errors++; $display("FAIL read_cmd: cmd_ok %0d dir_ok %0d required 1 1", cmd_ok, dir_ok); end
        checks++; if ({dn, er, od} !== 3'b100) begin errors++; $display("FAIL read_done: done/err/other %b required 100", {dn, er, od}); end
        checks++; if (ro !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata: got %h required deadbeef", ro); end
        exp_rd[0] = 32'hDEADBEEF;
    endtask

    task automatic test_timeout();
        run_xfer(1, 1, 0, 32'h40, 32'h0, 4'h3, 1, 0, 32'hCAFEF00D);
        checks++; if (ro !== 32'hCAFEF00D) begin errors++; $display("FAIL m1_read_rdata: got %h required cafef00d", ro); end
        run_xfer(1, 0, 1, 32'h200, 32'h12345678, 4'hF, 0, -1, 32'h0);
        checks++; if (nstb !== TO) begin errors++; $display("FAIL timeout_strobe_len: got %0d required %0d", nstb, TO); end
        checks++; if (!cmd_ok || !dir_ok) begin errors++; $display("FAIL timeout_cmd: cmd_ok %0d dir_ok %0d required 1 1", cmd_ok, dir_ok); end
        checks++; if ({dn, er, od, early} !== 4'b1100) begin errors++; $display("FAIL timeout_done: done/err/other/early %b required 1100", {dn, er, od, early}); end
        checks++; if (ro !== 32'h0) begin errors++; $display("FAIL timeout_rdata: got %h required 0", ro); end
        checks++; if (rt !== exp_rd[0]) begin errors++; $display("FAIL timeout_other_rdata: got %h required %h", rt, exp_rd[0]); end
        exp_rd[1] = 0;
    endtask

    task automatic test_rw_both();
        run_xfer(0, 1, 1, 32'h300, 32'hA5A5A5A5, 4'h1, 0, 0, 32'h11111111);
        checks++; if (!dir_ok) begin errors++; $display("FAIL rw_is_write: dir_ok got 0 required 1"); end
        checks++; if (ro !== exp_rd[0]) begin errors++; $display("FAIL rw_rdata_kept: got %h required %h", ro, exp_rd[0]); end
    endtask

    task automatic test_last_cycle();
        run_xfer(0, 1, 0, 32'h400, 32'h0, 4'hF, 1, TO - 1, 32'h76543210);
        checks++; if (nstb !== TO) begin errors++; $display("FAIL last_cycle_len: got %0d required %0d", nstb, TO); end
        checks++; if ({dn, er} !== 2'b10) begin errors++; $display("FAIL last_cycle_done: done/err %b required 10", {dn, er}); end
        checks++; if (ro !== 32'h76543210) begin errors++; $display("FAIL last_cycle_rdata: got %h required 76543210", ro); end
        exp_rd[0] = 32'h76543210;
    endtask

    task automatic test_ready_idle();
        s_ready = 1;
        s_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({s_re_o, s_we_o, m0_done_o, m1_done_o} !== 4'b0 || m0_rdata_o !== exp_rd[0] ||
                m1_rdata_o !== exp_rd[1]) begin
                errors++;
                $display("FAIL ready_in_idle: strobes/dones %b rdata %h %h required 0000 %h %h",
                         {s_re_o, s_we_o, m0_done_o, m1_done_o}, m0_rdata_o, m1_rdata_o, exp_rd[0], exp_rd[1]);
            end
        end
        s_ready = 0;
    endtask

    task automatic test_random();
        int m, k, exp_n;
        bit re, we, exp_err;
        logic [31:0] a, wd, srd;
        for (int it = 0; it < 24; it++) begin
            m  = int'($urandom_range(0, 1));
            we = 1'($urandom);
            re = we ? 1'($urandom) : 1'b1;
            k  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO + 2));
            a = $urandom; wd = $urandom; srd = $urandom;
            exp_err = !(k >= 0 && k < TO);
            exp_n   = exp_err ? TO : k + 1;
            run_xfer(m, re, we, a, wd, 4'($urandom), 1'($urandom), k, srd);
            if (exp_err) exp_rd[m] = 0;
            else if (!we) exp_rd[m] = srd;
            checks++; if (lat !== 1) begin errors++; $display("FAIL rnd%0d_latency: got %0d required 1", it, lat); end
            checks++; if (nstb !== exp_n) begin errors++; $display("FAIL rnd%0d_strobe_len: got %0d required %0d", it, nstb, exp_n); end
            checks++; if (!cmd_ok || !dir_ok) begin errors++; $display("FAIL rnd%0d_cmd: cmd_ok %0d dir_ok %0d required 1 1", it, cmd_ok, dir_ok); end
            checks++; if ({dn, er, od, early} !== {1'b1, exp_err, 2'b00}) begin errors++; $display("FAIL rnd%0d_done: done/err/other/early %b required %b", it, {dn, er, od, early}, {1'b1, exp_err, 2'b00}); end
            checks++; if (ro !== exp_rd[m] || rt !== exp_rd[1 - m]) begin errors++; $display("FAIL rnd%0d_rdata: got %h %h required %h %h", it, ro, rt, exp_rd[m], exp_rd[1 - m]); end
        end
    endtask

    task automatic test_reset_busy();
        int w;
        m_we[1] = 1; m_re[1] = 0; m_addr[1] = 32'h500; m_wdata[1] = 32'h12345678; m_mask[1] = 4'hF;
        w = 0;
        while (!s_we_o && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        @(negedge clk);
        #2 rst = 0;
        #1;
        checks++; if (all_outs() !== '0) begin errors++; $display("FAIL async_reset: got %h required 0", all_outs()); end
        @(posedge clk);
        #1;
        checks++; if (all_outs() !== '0) begin errors++; $display("FAIL reset_no_done: got %h required 0", all_outs()); end
        exp_rd[0] = 0; exp_rd[1] = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        checks++; if ({s_we_o, s_addr_o} !== {1'b1, 32'h500}) begin errors++; $display("FAIL regrant_after_reset: we/addr %b %h required 1 00000500", s_we_o, s_addr_o); end
        s_ready = 1;
        @(negedge clk);
        s_ready = 0;
        checks++; if ({m1_done_o, m1_err_o, m0_done_o} !== 3'b100) begin errors++; $display("FAIL regrant_done: %b required 100", {m1_done_o, m1_err_o, m0_done_o}); end
        m_we[1] = 0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int w, owner, exp_owner, model_last;
        logic [31:0] srd;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        exp_rd[0] = 0; exp_rd[1] = 0;
        model_last = 1;
        m_re[0] = 1; m_we[0] = 0; m_addr[0] = 32'hA0;
        m_re[1] = 1; m_we[1] = 0; m_addr[1] = 32'hB0;
        for (int i = 0; i < 3; i++) begin
            w = 0;
            while (!s_re_o && w < 50) begin @(negedge clk); w++; end
            exp_owner = 1 - model_last;
            owner = (s_addr_o == 32'hB0) ? 1 : 0;
            checks++; if (owner !== exp_owner) begin errors++; $display("FAIL rr%0d_owner: got %0d required %0d", i, owner, exp_owner); end
            srd = $urandom;
            s_ready = 1; s_rdata = srd;
            @(negedge clk);
            s_ready = 0;
            exp_rd[exp_owner] = srd;
            checks++; if ({m1_done_o, m0_done_o} !== 2'(1 << exp_owner)) begin errors++; $display("FAIL rr%0d_done: got %b required %b", i, {m1_done_o, m0_done_o}, 2'(1 << exp_owner)); end
            checks++; if (m0_rdata_o !== exp_rd[0] || m1_rdata_o !== exp_rd[1]) begin errors++; $display("FAIL rr%0d_rdata: got %h %h required %h %h", i, m0_rdata_o, m1_rdata_o, exp_rd[0], exp_rd[1]); end
            model_last = exp_owner;
            @(negedge clk);
        end
        m_re[0] = 0; m_re[1] = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_re[i] = 0; m_we[i] = 0; m_uns[i] = 0;
            m_addr[i] = 0; m_wdata[i] = 0; m_mask[i] = 0;
        end
        s_ready = 0;
        s_rdata = 0;
        test_reset();
        test_read();
        test_timeout();
        test_rw_both();
        test_last_cycle();
        test_ready_idle();
        test_random();
        test_reset_busy();
        test_round_robin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sb_arb.md
SB_ARB -- requirements
Module: sb_arb

Interface
REQ-001 Parameter: TIMEOUT, default 16, number of BUSY cycles without s_ready before a transfer is aborted (legal range 2..255).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous reset, active-low (0 = reset asserted).
REQ-005 m0_re / m0_we  input  1 each  master 0 read / write request.
REQ-006 m0_addr  input  32  master 0 address.
REQ-007 m0_wdata  input  32  master 0 write data.
REQ-008 m0_byte_mask  input  4  master 0 byte lane select.
REQ-009 m0_un_sign  input  1  master 0 unsigned-load flag, forwarded unchanged.
REQ-010 m0_done_o  output  1  one-cycle completion pulse to master 0.
REQ-011 m0_err_o  output  1  qualifies m0_done_o: transfer timed out.
REQ-012 m0_rdata_o  output  32  master 0 read data.
REQ-013 m1_* ports: identical set to REQ-005..REQ-012 for master 1.
REQ-014 s_re_o / s_we_o  output  1 each  slave read / write strobe, held for the whole transfer.
REQ-015 s_addr_o, s_wdata_o  output  32 each; s_byte_mask_o  output  4; s_un_sign_o  output  1  latched command of the granted master.
REQ-016 s_rdata  input  32  slave read data, valid with s_ready.
REQ-017 s_ready  input  1  slave completion, one cycle.

Function
REQ-018 States SHALL be IDLE, BUSY, RESP; a 1-bit owner register and a 1-bit last-served register (last).
REQ-019 A master requests when re|we is 1; if both re and we are 1, the transfer SHALL be a write.
REQ-020 IDLE, one requester: grant it; both requesting: grant the master != last (round robin); none: stay IDLE.
REQ-021 On grant (cycle N) the SHALL capture the owner's addr, wdata, byte_mask, un_sign, direction; at N+1 state is BUSY and s_* outputs drive the captured command.
REQ-022 Master inputs changing after grant SHALL NOT affect s_* outputs; masters hold request until done.
REQ-023 BUSY: timeout counter (8 bit) increments each cycle from 0; on s_ready go to RESP with success; else on counter == TIMEOUT-1 go to RESP with error.
REQ-024 s_ready and timeout in the same cycle: success wins.
REQ-025 RESP (one cycle): owner's done_o = 1, err_o per outcome; s_re_o/s_we_o = 0; last <= owner; next state IDLE; no arbitration in RESP.
REQ-026 Successful read: owner's rdata_o <= s_rdata captured on the s_ready cycle, visible in RESP and held thereafter; write success leaves rdata_o unchanged; error sets owner's rdata_o to 0.
REQ-027 Non-owner done_o/err_o/rdata_o SHALL remain unchanged/0 throughout.
REQ-028 s_ready in IDLE or RESP SHALL be ignored.
REQ-029 Latency: request at N, strobe at N+1, s_ready at M -> done at M+1; next grant earliest M+2, strobe M+3.

Reset
REQ-030 rst = 0 at any time, including mid-transfer, SHALL immediately force state IDLE, last = 1 (master 0 wins first tie), counter 0, all outputs 0; the aborted transfer produces no done.
REQ-031 After rst returns to 1, first grant SHALL occur on the first rising edge with a request.

Verification
REQ-032 m0 read addr 0x100, s_ready 2 cycles after strobe with s_rdata 0xDEADBEEF -> s_re_o=1, s_addr_o=0x100 for 2 cycles; m0_done_o=1, m0_err_o=0, m0_rdata_o=0xDEADBEEF.
REQ-033 m0 and m1 request together from reset, s_ready each after 1 cycle -> m0 served first, then m1, then m0 again if both still requesting; no cycle with both done.
REQ-034 m1 write wdata 0x12345678 mask 0xF, s_ready never -> s_we_o high for exactly 16 cycles, m1_done_o=1, m1_err_o=1, m1_rdata_o=0.
REQ-035 m0 re=1 and we=1 -> s_we_o=1, s_re_o=0.
REQ-036 rst=0 in BUSY -> all outputs 0 asynchronously, no done; after release, pending m1 request granted next edge.
REQ-037 s_ready on cycle TIMEOUT-1 of BUSY -> done with err=0.
